// File: rtl/pipe_pkg.sv
// Types and constants shared by the MEM stage of the pipeline.
package pipe_pkg;
  localparam int DW = 16;
  localparam int REG_AW = 4;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} mem_state_t;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] wb_reg;
    logic              we;
    logic [DW-1:0]     data;
  } mem_wb_t;
endpackage

// File: rtl/mem_access_stage_timer.sv
// Wait-cycle counter for an outstanding data-memory request.
module mem_wait_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic expire
);
  localparam int W = $clog2(TIMEOUT + 1);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clear)
      cnt_q <= '0;
    else if (en && !expire)
      cnt_q <= cnt_q + 1'b1;
  end

  assign expire = (cnt_q == W'(TIMEOUT - 1));
endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: req/ack access to data memory, stalls EX/MEM, owns MEM/WB.
module mem_access_stage #(
  parameter int DW = 16,
  parameter int AW = 16,
  parameter int TIMEOUT = 15
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        valid_in,
  input  logic [DW-1:0]               alu_result_in,
  input  logic [DW-1:0]               store_data_in,
  input  logic                        mem_write_in,
  input  logic                        mem_read_in,
  input  logic [pipe_pkg::REG_AW-1:0] wb_reg_in,
  input  logic                        reg_write_in,
  output logic                        stall_n_out,
  output logic                        mem_req_out,
  output logic                        mem_we_out,
  output logic [AW-1:0]               mem_addr_out,
  output logic [DW-1:0]               mem_wdata_out,
  input  logic                        mem_ack_in,
  input  logic [DW-1:0]               mem_rdata_in,
  output logic                        wb_valid_out,
  output logic [DW-1:0]               wb_data_out,
  output logic [pipe_pkg::REG_AW-1:0] wb_reg_out,
  output logic                        reg_write_out,
  output logic                        err_timeout_out,
  output logic                        err_misalign_out
);
  import pipe_pkg::*;

  mem_state_t    state_q, state_d;
  mem_wb_t       wb_q;
  logic [DW-1:0] rdata_q;
  logic [DW-1:0] wb_data_d;
  logic          is_mem, access, misalign;
  logic          issue, busy, stall_n, expire;

  assign is_mem   = valid_in & (mem_read_in | mem_write_in);
  assign access   = is_mem & ~alu_result_in[0];
  assign misalign = is_mem & alu_result_in[0];
  assign busy     = (state_q == BUSY);
  assign issue    = (state_q == IDLE) & access;
  assign stall_n  = ~(issue | busy);

  mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (~busy),
    .en     (busy),
    .expire (expire)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (access) state_d = BUSY;
      BUSY:    if (mem_ack_in || expire) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Loads retire the captured read data; everything else the ALU result.
  always_comb begin
    wb_data_d = alu_result_in;
    unique case (1'b1)
      (state_q == DONE) && mem_read_in: wb_data_d = rdata_q;
      default:                          wb_data_d = alu_result_in;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= IDLE;
      mem_req_out      <= 1'b0;
      mem_we_out       <= 1'b0;
      mem_addr_out     <= '0;
      mem_wdata_out    <= '0;
      rdata_q          <= '0;
      err_timeout_out  <= 1'b0;
      err_misalign_out <= 1'b0;
      wb_q             <= '0;
    end else begin
      state_q          <= state_d;
      err_misalign_out <= misalign & stall_n;
      if (issue) begin
        mem_req_out   <= 1'b1;
        mem_we_out    <= mem_write_in;
        mem_addr_out  <= alu_result_in[AW-1:0];
        mem_wdata_out <= store_data_in;
      end
      if (busy && mem_ack_in) begin
        mem_req_out <= 1'b0;
        rdata_q     <= mem_rdata_in;
      end else if (busy && expire) begin
        mem_req_out     <= 1'b0;
        rdata_q         <= '0;
        err_timeout_out <= 1'b1;
      end
      if (stall_n) begin
        wb_q.valid  <= valid_in;
        wb_q.wb_reg <= wb_reg_in;
        wb_q.we     <= reg_write_in & valid_in & ~misalign;
        wb_q.data   <= wb_data_d;
      end else begin
        wb_q.valid <= 1'b0;
        wb_q.we    <= 1'b0;
      end
    end
  end

  assign stall_n_out   = stall_n;
  assign wb_valid_out  = wb_q.valid;
  assign wb_reg_out    = wb_q.wb_reg;
  assign reg_write_out = wb_q.we;
  assign wb_data_out   = wb_q.data;
endmodule
